// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int UART_BYTE_W = 8;
  localparam int NUM_REQ_MAX = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: selects the first requester at or after
// last_g+1 (wrapping) and returns it one-hot and as an index.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_g,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  // Scan from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      int idx;
      idx = int'(last_g) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
        pick_idx  = IDX_W'(idx);
        pick_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-locked round-robin arbiter onto a single UART TX byte stream.
// Optional abandoned-frame timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_valid,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]     g_reg, g_next;
  logic [IDX_W-1:0]     last_g_reg, last_g_next;

  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic [UART_BYTE_W-1:0] req_bytes [NUM_REQ];
  logic                 locked;
  logic                 accept_en;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 xfer;
  logic                 timeout_hit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req_valid),
    .last_g   (last_g_reg),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_bytes[gi] = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
      assign req_ready[gi] = accept_en && (g_reg == IDX_W'(gi)) && tx_ready;
    end
  endgenerate

  assign locked      = (state_reg == ARB_LOCKED);
  assign owner_valid = req_valid[g_reg];
  assign owner_last  = req_last[g_reg];
  // The timeout cycle is a release cycle: nothing is offered or accepted.
  assign accept_en   = locked && !timeout_hit;
  assign tx_valid    = accept_en && owner_valid;
  assign tx_data     = accept_en ? req_bytes[g_reg] : '0;
  assign xfer        = tx_valid && tx_ready;

  assign grant         = grant_reg;
  assign busy          = locked;
  assign timeout_pulse = timeout_hit;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign timeout_hit = locked && (cnt_reg >= CNT_W'(TIMEOUT_CYCLES));

  // Only an absent byte counts as stall; serializer backpressure never does.
  always_comb begin
    cnt_next = cnt_reg;
    if (!locked || xfer) begin
      cnt_next = '0;
    end else if (!owner_valid && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    g_next      = g_reg;
    last_g_next = last_g_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_LOCKED;
          grant_next = pick;
          g_next     = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (timeout_hit || (xfer && owner_last)) begin
          state_next  = ARB_IDLE;
          grant_next  = '0;
          last_g_next = g_reg;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ARB_IDLE;
      grant_reg  <= '0;
      g_reg      <= '0;
      last_g_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      g_reg      <= g_next;
      last_g_reg <= last_g_next;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-locked round-robin arbiter that shares the chip's single UART transmit byte stream among several requesters. Typical requesters are the core console, the ft_link debug bridge and the boot monitor. It sits between the requesters' valid/ready byte streams and the UART TX serializer that drives `uart_rxd_out`. A grant is held from a frame's first byte to its last byte, so frames from different requesters never interleave.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 100_000: stall limit in clock cycles for an abandoned frame (1 ms at 100 MHz). Must be at least 2.
- `CNT_W`, default `$clog2(TIMEOUT_CYCLES+1)`: width of the stall counter.

Ports:
- `clock`  in  1: system clock (100 MHz).
- `reset_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ: per-requester byte valid.
- `req_data`  in  NUM_REQ*8: per-requester byte. Requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ: marks the final byte of a frame.
- `req_ready`  out  NUM_REQ: per-requester accept.
- `tx_valid`  out  1: byte valid toward the UART serializer.
- `tx_data`  out  8: byte toward the UART serializer.
- `tx_ready`  in  1: serializer accepts the byte.
- `grant`  out  NUM_REQ: one-hot current owner. All zero when idle.
- `busy`  out  1: high while in LOCKED.
- `timeout_pulse`  out  1: one-cycle pulse when a frame is aborted.

## Operation
- State machine has two states, IDLE and LOCKED. The state, `grant`, the round-robin pointer `last_g` and the stall counter are all registered.
- **IDLE**
  - `tx_valid`=0 and `req_ready`=0.
  - If any `req_valid` is high, go to LOCKED. The grant goes to the first valid requester searching upward from `last_g+1`, wrapping modulo NUM_REQ.
  - If no `req_valid` is high, stay in IDLE.
- **LOCKED**, owner g:
  - `tx_valid`=`req_valid[g]`, `tx_data`=`req_data[g]`, `req_ready[g]`=`tx_ready`. These are combinational pass-through paths.
  - All other `req_ready` bits are 0.
  - A transfer is `req_valid[g] & tx_ready`.
  - A transfer with `req_last[g]`=1 returns to IDLE and sets `last_g`=g.
- **Stall counter**
  - Clears on every transfer and on entry to LOCKED.
  - Increments in each LOCKED cycle where `req_valid[g]`=0.
  - Saturates; it never wraps.
  - The counter does not increment while `req_valid[g]`=1 and `tx_ready`=0. Serializer backpressure never causes a timeout.
- **Simultaneous requests**: exactly one grant. Losers keep `req_valid` asserted and are served in rotation order.
- **Single-byte frame**: a byte with `req_last`=1 as the first beat is one transfer, then IDLE.
- The IDLE cycle after each frame is mandatory. Back-to-back frames from the same requester are allowed when no other requester is waiting.

## Timing
- Arbitration latency: the first byte can transfer no earlier than 1 cycle after `req_valid` rises in IDLE.
- Within a frame: 0-cycle latency from `req_valid` to `tx_valid`, and full throughput of 1 byte per cycle when `tx_ready`=1.
- Frame turnaround: 1 IDLE cycle between the last byte and the next grant.
- Reset values:
  - state IDLE.
  - `grant`=0, `busy`=0, `tx_valid`=0, `tx_data`=0, `req_ready`=0, `timeout_pulse`=0.
  - counter 0.
  - `last_g`=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronous). The partial frame is dropped, and the serializer sees `tx_valid` fall without a transfer.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- **Defined**: when the counter reaches TIMEOUT_CYCLES in LOCKED, the arbiter:
  - drives `timeout_pulse`=1 for one cycle,
  - returns to IDLE,
  - sets `last_g`=g,
  - accepts no byte in that cycle.
- **Undefined**:
  - the counter logic is removed and `timeout_pulse` is tied to 0;
  - a grant is released only by a transfer with `req_last`.

## Structure
- Shared package `uart_arb_pkg`:
  - `arb_state_e` enum {ARB_IDLE, ARB_LOCKED},
  - `UART_BYTE_W`=8,
  - `NUM_REQ_MAX`=8.
- Sub-module `rr_picker`:
  - combinational, parameterized by NUM_REQ;
  - inputs: request vector and `last_g`;
  - outputs: one-hot pick and its index.
- The top level holds the FSM, the mux and the counter.

## Test plan
- **Single frame**: requester 0 sends 0x41, 0x42, 0x0A (last) with `tx_ready`=1 → `tx_data` shows 0x41, 0x42, 0x0A on 3 consecutive cycles starting 1 cycle after `req_valid`; `busy` falls after 0x0A.
- **Contention**: both requesters raise `req_valid` in the same cycle with 2-byte frames → requester 0's frame completes entirely, 1 IDLE cycle follows, then requester 1's frame; no interleaving.
- **Fairness**: NUM_REQ=3, all three continuously send 1-byte frames → grants rotate 0,1,2,0,1,2.
- **Backpressure**: `tx_ready` held low for 200,000 cycles mid-frame with `req_valid`=1 → no `timeout_pulse`; the frame finishes when `tx_ready` returns.
- **Timeout** (`UART_TX_ARB_TIMEOUT_EN` defined, TIMEOUT_CYCLES=16): requester 0 sends 1 byte without last, then drops `req_valid` → `timeout_pulse` occurs 16 cycles later and requester 1 is granted on the next cycle.
- **Reset mid-frame**: `reset_n` driven low during byte 2 of a 4-byte frame → `tx_valid`, `grant` and `busy` go to 0 immediately; after release, requester 0 is granted first.
